uart_tx_pacer: RTL and testbench
================================

// Module: uart_tx_pacer
// PURPOSE
//   Byte FIFO and frame pacer between uart_rx and uart_tx in the RS-232 echo path.
//   Buffers received bytes (pi_data/pi_data_flag pulse) and re-issues them as
//   one-cycle po_data_flag pulses, spaced one full UART frame apart.
//   uart_tx has no busy output, so this spacing keeps it from being overrun
//   during rx bursts.
// PARAMETERS
//   BAUD_CNT_MAX  13'd5207  clock cycles per bit minus 1; must match uart_tx
//   FRAME_BITS    4'd10     bits per frame (start + 8 data + stop)
//   DEPTH_LOG2    4         FIFO depth = 2**DEPTH_LOG2 bytes
// PORTS
//   sys_clk       in   1             system clock
//   sys_rst       in   1             synchronous reset, active-high
//   pi_data       in   8             byte from uart_rx
//   pi_data_flag  in   1             one-cycle strobe: pi_data valid
//   po_data       out  8             byte to uart_tx; held until the next strobe
//   po_data_flag  out  1             one-cycle strobe to uart_tx
//   fifo_level    out  DEPTH_LOG2+1  bytes currently queued
//   overflow      out  1             sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//   - Reset: po_data=8'h00, po_data_flag=0, fifo_level=0, overflow=0.
//     Reset also clears both FIFO pointers and the gap counter. It takes effect mid-gap too.
//   - Frame period P = (BAUD_CNT_MAX+1)*FRAME_BITS cycles.
//     The gap counter width is $clog2(P).
//   - FIFO: RAM of 2**DEPTH_LOG2 x 8. Read and write pointers are DEPTH_LOG2+1 bits and wrap naturally.
//     empty = pointers equal; full = MSBs differ and the other bits are equal.
//   - Write: on pi_data_flag && !full, store the byte and advance wr_ptr.
//     On pi_data_flag && full, drop the byte, set overflow, leave the pointers unchanged.
//     full is taken from registered state; a read in the same cycle does not make room.
//   - States: IDLE (gap_cnt==0), GAP (gap_cnt!=0).
//     IDLE && !empty: register po_data <= head, pulse po_data_flag, advance rd_ptr,
//       load gap_cnt <= P-1, go to GAP.
//     IDLE && empty: no action.
//     GAP: decrement gap_cnt each cycle. Return to IDLE when it reaches 0.
//   - Timing: strobe pulses are exactly P cycles apart while the FIFO stays non-empty.
//     Latency from a write into an empty FIFO in IDLE to po_data_flag is 1 cycle. There is no bypass.
//   - Simultaneous write and read: both take effect, so fifo_level is unchanged.
//   - fifo_level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1), registered.
//   - overflow is cleared only by reset.
// CONFIGURATION
//   OVERFLOW_CNT_EN defined: adds output port ovf_cnt [7:0].
//     It resets to 0, increments on each dropped byte, and saturates at 8'hFF.
//   OVERFLOW_CNT_EN undefined: port and counter are absent. Only the sticky overflow remains.
// TESTING  (BAUD_CNT_MAX=3, FRAME_BITS=10 -> P=40; DEPTH_LOG2=2 -> depth 4)
//   1. sys_rst high 2 cycles -> po_data_flag=0, po_data=00, fifo_level=0, overflow=0.
//   2. One write of 8'hA5 at cycle t while idle -> po_data_flag high only at t+1, po_data=A5;
//      no further strobe.
//   3. Writes 11,22,33 at t,t+1,t+2 -> strobes at t+1,t+41,t+81 carrying 11,22,33 in order.
//   4. Writes of 6 bytes on consecutive cycles t..t+5 from idle -> byte 6 dropped, overflow=1;
//      bytes 1-5 emitted P apart.
//   5. Two bytes queued; assert sys_rst 10 cycles after a strobe -> fifo_level=0 and gap cleared;
//      no strobe until a new write, which then strobes 1 cycle later.
//   6. OVERFLOW_CNT_EN: 3 dropped bytes -> ovf_cnt=3; 300 dropped bytes -> ovf_cnt=FF.

Source files
------------

// File: rtl/uart_tx_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pacer
//  Purpose  : Byte FIFO plus frame pacer sitting between uart_rx and uart_tx
//             in the RS-232 echo path. Received bytes are queued and re-issued
//             as one-cycle strobes spaced one full UART frame apart. uart_tx
//             has no busy output, so this spacing keeps it from being overrun
//             when uart_rx delivers a burst.
//
//  Parameters
//    BAUD_CNT_MAX : clock cycles per bit minus 1 (must match uart_tx)
//    FRAME_BITS   : bits per UART frame (start + 8 data + stop)
//    DEPTH_LOG2   : FIFO depth is 2**DEPTH_LOG2 bytes (must be >= 1)
//
//  Ports
//    sys_clk      in   1             system clock
//    sys_rst      in   1             synchronous reset, active-high
//    pi_data      in   8             byte from uart_rx
//    pi_data_flag in   1             one-cycle strobe, pi_data valid
//    po_data      out  8             byte to uart_tx, held until next strobe
//    po_data_flag out  1             one-cycle strobe to uart_tx
//    fifo_level   out  DEPTH_LOG2+1  bytes currently queued
//    overflow     out  1             sticky: a byte was dropped on a full FIFO
//    ovf_cnt      out  8             saturating count of dropped bytes
//                                    (present only with OVERFLOW_CNT_EN)
//
//  Build option
//    OVERFLOW_CNT_EN : when defined, adds the ovf_cnt output and its counter.
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_pacer #(
    parameter logic [12:0] BAUD_CNT_MAX = 13'd5207,
    parameter logic [3:0]  FRAME_BITS   = 4'd10,
    parameter int          DEPTH_LOG2   = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [7:0]            pi_data,
    input  logic                  pi_data_flag,
    output logic [7:0]            po_data,
    output logic                  po_data_flag,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow
`ifdef OVERFLOW_CNT_EN
    ,
    output logic [7:0]            ovf_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // Frame period in clock cycles; strobes are issued exactly this far apart.
    localparam int C_PERIOD = (int'(BAUD_CNT_MAX) + 1) * int'(FRAME_BITS);
    localparam int C_GAP_W  = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;
    localparam int C_DEPTH  = 1 << DEPTH_LOG2;
    localparam int C_PTR_W  = DEPTH_LOG2 + 1;

    // The strobe cycle itself counts as the first cycle of the period, so the
    // gap counter is loaded with P-1 and the next strobe lands P cycles later.
    localparam logic [C_GAP_W-1:0] C_GAP_LOAD = C_GAP_W'(C_PERIOD - 1);
    localparam logic [C_GAP_W-1:0] C_GAP_ONE  = C_GAP_W'(1);

    // ------------------------------------------------------------------------
    // Pacer state machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // gap counter is zero, free to issue a byte
        ST_GAP  = 1'b1    // waiting out the current frame
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [C_GAP_W-1:0]     r_gap_cnt;
    logic [C_GAP_W-1:0]     w_gap_nxt;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [7:0]             r_mem [C_DEPTH];
    logic [C_PTR_W-1:0]     r_wr_ptr;
    logic [C_PTR_W-1:0]     r_rd_ptr;
    logic [C_PTR_W-1:0]     w_wr_ptr_nxt;
    logic [C_PTR_W-1:0]     w_rd_ptr_nxt;
    logic [C_PTR_W-1:0]     r_level;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_wr_en;
    logic                   w_drop;
    logic                   w_rd_en;
    logic [7:0]             w_head;

    logic [7:0]             r_po_data;
    logic                   r_po_data_flag;
    logic                   r_overflow;

    // Full/empty come only from registered pointers: a read happening in the
    // same cycle as a write never makes room for that write.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[C_PTR_W-1] != r_rd_ptr[C_PTR_W-1]) &&
                     (r_wr_ptr[C_PTR_W-2:0] == r_rd_ptr[C_PTR_W-2:0]);

    assign w_wr_en = pi_data_flag && !w_full;
    assign w_drop  = pi_data_flag &&  w_full;

    assign w_head  = r_mem[r_rd_ptr[C_PTR_W-2:0]];

    // Pointers are one bit wider than the address and wrap naturally.
    assign w_wr_ptr_nxt = w_wr_en ? (r_wr_ptr + C_PTR_W'(1)) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_en ? (r_rd_ptr + C_PTR_W'(1)) : r_rd_ptr;

    // ------------------------------------------------------------------------
    // Pacer FSM: next-state and control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_rd_en     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_rd_en   = 1'b1;
                    w_gap_nxt = C_GAP_LOAD;
                    // A one-cycle period needs no gap at all.
                    w_state_nxt = (C_GAP_LOAD == '0) ? ST_IDLE : ST_GAP;
                end
            end

            ST_GAP: begin
                if (r_gap_cnt <= C_GAP_ONE) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - C_GAP_ONE;
                end
            end

            default: begin
                w_gap_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM and gap counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO RAM: written only when there is room, contents need no reset
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (w_wr_en && !sys_rst) begin
            r_mem[r_wr_ptr[C_PTR_W-2:0]] <= pi_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, level and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_po_data      <= 8'h00;
            r_po_data_flag <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            // Level tracks the pointer difference of the values being stored,
            // so a simultaneous push and pop leaves it unchanged.
            r_level        <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_po_data_flag <= w_rd_en;
            if (w_rd_en) begin
                r_po_data <= w_head;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign po_data      = r_po_data;
    assign po_data_flag = r_po_data_flag;
    assign fifo_level   = r_level;
    assign overflow     = r_overflow;

    // ------------------------------------------------------------------------
    // Optional saturating count of dropped bytes
    // ------------------------------------------------------------------------
`ifdef OVERFLOW_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ovf_cnt <= 8'h00;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_pacer
//  Purpose  : Directed self-checking bench for uart_tx_pacer with a short
//             frame (BAUD_CNT_MAX=3, FRAME_BITS=10 -> P=40) and a 4-deep FIFO.
//             Strobes are logged with their clock-edge index and compared
//             against hand-computed schedules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_pacer;

    localparam int P = 40;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] pi_data;
    logic       pi_data_flag;
    logic [7:0] po_data;
    logic       po_data_flag;
    logic [2:0] fifo_level;
    logic       overflow;
`ifdef OVERFLOW_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    uart_tx_pacer #(
        .BAUD_CNT_MAX (13'd3),
        .FRAME_BITS   (4'd10),
        .DEPTH_LOG2   (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .pi_data      (pi_data),
        .pi_data_flag (pi_data_flag),
        .po_data      (po_data),
        .po_data_flag (po_data_flag),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
`ifdef OVERFLOW_CNT_EN
        ,
        .ovf_cnt      (ovf_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Edge counter: at any point after posedge k it holds k.
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Strobe log, sampled on the falling edge.
    typedef struct {
        int         cyc;
        logic [7:0] data;
    } strobe_t;
    strobe_t q[$];

    always @(negedge sys_clk) begin
        if (po_data_flag === 1'b1) q.push_back('{cyc, po_data});
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Presents one byte for one clock; returns the edge index that sampled it.
    task automatic write_byte(input logic [7:0] d, output int t);
        pi_data      = d;
        pi_data_flag = 1'b1;
        tick();
        pi_data_flag = 1'b0;
        t = cyc;
    endtask

    function automatic int q_cyc(input int i);
        return (i < q.size()) ? q[i].cyc : -1;
    endfunction

    function automatic int q_dat(input int i);
        return (i < q.size()) ? int'(q[i].data) : -1;
    endfunction

    initial begin
        int t;
        int t0;
        logic [7:0] b3 [3];

        sys_rst      = 1'b1;
        pi_data      = 8'h00;
        pi_data_flag = 1'b0;

        // ---- 1: reset state ----
        run(2);
        check("rst_flag",  po_data_flag, 0);
        check("rst_data",  po_data, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_ovf",   overflow, 0);
        sys_rst = 1'b0;
        run(2);

        // ---- 2: single byte, one-cycle latency, no repeat ----
        q.delete();
        write_byte(8'hA5, t);
        check("s2_flag_at_t", po_data_flag, 0);
        tick();
        check("s2_flag_t1", po_data_flag, 1);
        check("s2_data_t1", po_data, 8'hA5);
        run(100);
        check("s2_count", q.size(), 1);
        check("s2_cyc",   q_cyc(0), t + 1);
        check("s2_held",  po_data, 8'hA5);
        check("s2_level", fifo_level, 0);

        // ---- 3: three back-to-back bytes paced P apart ----
        q.delete();
        b3[0] = 8'h11; b3[1] = 8'h22; b3[2] = 8'h33;
        write_byte(b3[0], t0);
        write_byte(b3[1], t);
        write_byte(b3[2], t);
        check("s3_level", fifo_level, 2);
        run(130);
        check("s3_count", q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("s3_cyc", q_cyc(i), t0 + 1 + P * i);
            check("s3_dat", q_dat(i), int'(b3[i]));
        end

        // ---- 4: burst of six into a 4-deep FIFO ----
        q.delete();
        write_byte(8'h01, t0);
        for (int i = 2; i <= 5; i++) write_byte(8'(i), t);
        check("s4_level_full", fifo_level, 4);
        check("s4_ovf_before", overflow, 0);
        write_byte(8'h06, t);
        check("s4_ovf_after",  overflow, 1);
        check("s4_level_drop", fifo_level, 4);
        run(200);
        check("s4_count", q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("s4_cyc", q_cyc(i), t0 + 1 + P * i);
            check("s4_dat", q_dat(i), i + 1);
        end
        check("s4_ovf_sticky", overflow, 1);
        check("s4_level_end",  fifo_level, 0);

        // ---- 5: reset mid-gap clears FIFO and gap counter ----
        q.delete();
        write_byte(8'h77, t0);
        write_byte(8'h88, t);
        run(9);
        check("s5_level_pre", fifo_level, 1);
        check("s5_data_pre",  po_data, 8'h77);
        sys_rst = 1'b1;
        tick();
        check("s5_level_rst", fifo_level, 0);
        check("s5_data_rst",  po_data, 8'h00);
        check("s5_flag_rst",  po_data_flag, 0);
        check("s5_ovf_rst",   overflow, 0);
        tick();
        sys_rst = 1'b0;
        q.delete();
        run(100);
        check("s5_no_strobe", q.size(), 0);
        write_byte(8'h5C, t);
        run(3);
        check("s5_count", q.size(), 1);
        check("s5_cyc",   q_cyc(0), t + 1);
        check("s5_dat",   q_dat(0), 8'h5C);
        run(50);

`ifdef OVERFLOW_CNT_EN
        // ---- 6: saturating drop counter ----
        check("s6_cnt_zero", ovf_cnt, 0);
        for (int i = 0; i < 8; i++) write_byte(8'(8'hC0 + i), t);
        check("s6_cnt_3", ovf_cnt, 3);
        check("s6_ovf",   overflow, 1);
        for (int i = 0; i < 300; i++) write_byte(8'(i), t);
        check("s6_cnt_sat", ovf_cnt, 8'hFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
